// File: rtl/seq_divider.sv
// Restoring unsigned divider, one trial subtraction per cycle; done N cycles after start (1 cycle for divide-by-zero).
// No backpressure: start is taken only when not busy, and the results hold until the next accepted start.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  // ZERO is a single non-busy cycle that gives divide-by-zero its one-cycle latency.
  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  state_t         state, state_nxt;
  logic [N:0]     r_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   d_q;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last;
  logic [N:0]     r_sh;
  logic [N:0]     t;
  logic           no_borrow;
  logic [N:0]     r_step;
  logic [N-1:0]   q_step;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(N - 1));

  // Trial subtraction as an add of the complement; carry-out means no borrow.
  always_comb begin
    r_sh               = {r_q[N-1:0], q_q[N-1]};
    {no_borrow, t}     = {1'b0, r_sh} + {1'b0, ~{1'b0, d_q}} + {{(N+1){1'b0}}, 1'b1};
    r_step             = no_borrow ? t : r_sh;
    q_step             = {q_q[N-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = (divisor == '0) ? ZERO : CALC;
        else if (state == DONE) state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      ZERO:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt <= '0;
    end else if (accept) begin
      r_q <= '0;
      q_q <= dividend;
      d_q <= divisor;
      cnt <= '0;
    end else if (state == CALC) begin
      r_q <= r_step;
      q_q <= q_step;
      cnt <= cnt + 1'b1;
    end
  end

  // Results move only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == CALC && last) begin
      quotient    <= q_step;
      remainder   <= r_step[N-1:0];
      div_by_zero <= 1'b0;
    end else if (state == ZERO) begin
      quotient    <= '1;
      remainder   <= q_q;
      div_by_zero <= 1'b1;
    end
  end

  a_rem_msb_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (state == CALC && last) |-> !r_step[N]);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus a random sweep at N=8 and N=16,
// checked against plain / and % arithmetic with the expected cycle latency.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st8 = 1'b0, st16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, dz8, busy16, done16, dz16;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic        sel16 = 1'b0;
  logic        o_busy, o_done, o_dz;
  logic [31:0] o_q, o_r;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  seq_divider #(.N(16)) u_div16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
  );

  assign o_busy = sel16 ? busy16 : busy8;
  assign o_done = sel16 ? done16 : done8;
  assign o_dz   = sel16 ? dz16 : dz8;
  assign o_q    = sel16 ? {16'b0, q16} : {24'b0, q8};
  assign o_r    = sel16 ? {16'b0, r16} : {24'b0, r8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("excl8", {31'b0, busy8 & done8}, 32'd0);
    check("excl16", {31'b0, busy16 & done16}, 32'd0);
  end

  task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w == 16) begin
      st16 = s; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      st8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // Called at a negedge with the DUT idle or in DONE; returns at a negedge in IDLE.
  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [31:0] mask, exp_q, exp_r;
    int          exp_lat, cnt;
    bit          seen;
    mask    = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
    exp_q   = (b == 0) ? mask : a / b;
    exp_r   = (b == 0) ? a : a % b;
    exp_lat = (b == 0) ? 1 : w;
    sel16   = (w == 16);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    cnt  = 0;
    seen = 0;
    while (cnt < 40 && !seen) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) drive(w, 1'b0, $urandom, $urandom);
      if (disturb && cnt == 3) drive(w, 1'b1, 32'd50, 32'd5);
      if (disturb && cnt == 4) drive(w, 1'b0, $urandom, $urandom);
      if (o_done) seen = 1;
      else check("busy_during_op", {31'b0, o_busy}, {31'b0, b != 0});
    end
    check("latency", cnt - 1, exp_lat);
    check("quotient", o_q, exp_q);
    check("remainder", o_r, exp_r);
    check("div_by_zero", {31'b0, o_dz}, {31'b0, b == 0});
    check("busy_at_done", {31'b0, o_busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, o_done}, 32'd0);
    check("quotient_held", o_q, exp_q);
    check("remainder_held", o_r, exp_r);
  endtask

  initial begin
    int first, second, ndone;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_q", {24'b0, q8}, 32'd0);
    check("rst_r", {24'b0, r8}, 32'd0);
    check("rst_dz", {31'b0, dz8}, 32'd0);
    rst_n = 1'b1;

    op(8, 100, 7, 0);

    // Reset in the middle of a second operation.
    drive(8, 1'b1, 200, 13);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy8}, 32'd0);
    check("midrst_done", {31'b0, done8}, 32'd0);
    check("midrst_q", {24'b0, q8}, 32'd0);
    check("midrst_r", {24'b0, r8}, 32'd0);
    check("midrst_dz", {31'b0, dz8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    op(8, 255, 1, 0);
    op(8, 255, 255, 0);
    op(8, 5, 9, 0);
    op(8, 0, 3, 0);
    op(8, 37, 0, 0);
    op(8, 9, 3, 0);
    op(8, 200, 13, 1);

    // start held high: second operation accepted in the DONE cycle.
    sel16 = 1'b0;
    drive(8, 1'b1, 200, 13);
    @(posedge clk);
    first = 0; second = 0; ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) drive(8, 1'b1, 77, 10);
      if (done8) begin
        ndone++;
        if (first == 0) begin
          first = i;
          check("b2b_q1", {24'b0, q8}, 32'd15);
          check("b2b_r1", {24'b0, r8}, 32'd5);
        end else if (second == 0) begin
          second = i;
          check("b2b_q2", {24'b0, q8}, 32'd7);
          check("b2b_r2", {24'b0, r8}, 32'd7);
          drive(8, 1'b0, 0, 0);
        end
      end else if (first != 0 && second == 0) begin
        check("b2b_q1_held", {24'b0, q8}, 32'd15);
      end
    end
    check("b2b_gap", second - first, 9);
    check("b2b_count", ndone, 2);

    for (int i = 0; i < 600; i++) begin
      a = $urandom & 32'hFF;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'hFF);
      op(8, a, b, 0);
    end
    for (int i = 0; i < 600; i++) begin
      a = $urandom & 32'hFFFF;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'hFFFF);
      op(16, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
